// File: rtl/seg_pkg.sv
// Shared segment-bus constants used by the 7-segment scan driver and the capture block.
package seg_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Glyphs are {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  localparam logic [7:0] ASCII_BLANK = 8'h20;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  typedef enum logic {StCollect, StPublish} cap_state_e;

  typedef enum logic [1:0] {PosBlank, PosValid, PosIllegal} pos_class_e;

  function automatic pos_class_e classify_pos(input logic [3:0] pos);
    pos_class_e cls;
    if (pos == 4'b0000) begin
      cls = PosBlank;
    end else if ((pos & (pos - 4'd1)) == 4'b0000) begin
      cls = PosValid;
    end else begin
      cls = PosIllegal;
    end
    return cls;
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational 7-segment glyph to ASCII decoder; unknown patterns map to '?'.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [7:0] ascii_o,
  output logic       legal_o
);

  always_comb begin
    ascii_o = ASCII_QMARK;
    legal_o = 1'b1;
    case (pattern_i)
      GLYPH_0:     ascii_o = 8'h30;
      GLYPH_1:     ascii_o = 8'h31;
      GLYPH_2:     ascii_o = 8'h32;
      GLYPH_3:     ascii_o = 8'h33;
      GLYPH_4:     ascii_o = 8'h34;
      GLYPH_5:     ascii_o = 8'h35;
      GLYPH_6:     ascii_o = 8'h36;
      GLYPH_7:     ascii_o = 8'h37;
      GLYPH_8:     ascii_o = 8'h38;
      GLYPH_9:     ascii_o = 8'h39;
      GLYPH_A:     ascii_o = 8'h41;
      GLYPH_B:     ascii_o = 8'h42;
      GLYPH_C:     ascii_o = 8'h43;
      GLYPH_D:     ascii_o = 8'h44;
      GLYPH_E:     ascii_o = 8'h45;
      GLYPH_F:     ascii_o = 8'h46;
      GLYPH_DASH:  ascii_o = 8'h2D;
      GLYPH_BLANK: ascii_o = ASCII_BLANK;
      default: begin
        ascii_o = ASCII_QMARK;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Reconstructs the 4-character string shown on a scanned 7-segment display bus.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int unsigned P_STABLE  = 16,
  parameter int unsigned P_TIMEOUT = 2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  i_seg_pos,
  input  logic [7:0]  i_seg,
  output logic [31:0] o_data,
  output logic [3:0]  o_dp,
  output logic        o_valid,
  output logic        o_changed,
  output logic        o_err,
  output logic        o_timeout
);

  localparam int unsigned RunW = $clog2(P_STABLE + 1);
  localparam int unsigned TmoW = $clog2(P_TIMEOUT + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(P_STABLE);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(P_TIMEOUT);

  logic [3:0]       s_pos_q, p_pos_q;
  logic [7:0]       s_seg_q, p_seg_q;
  logic [RunW-1:0]  run_q, run_d;
  logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0][7:0]  shadow_q, data_q;
  logic [3:0]       dp_sh_q, dp_q;
  logic             valid_q, changed_q, err_q, tmo_q, tmo_d, err_d;
  cap_state_e       state_q;

  pos_class_e pos_class;
  logic       same, accept, publish;
  logic [7:0] glyph_ascii;
  logic       glyph_legal;

  seg_glyph_decode u_decode (
    .pattern_i(s_seg_q[6:0]),
    .ascii_o  (glyph_ascii),
    .legal_o  (glyph_legal)
  );

  always_comb begin
    pos_class = classify_pos(s_pos_q);
    same      = {s_pos_q, s_seg_q} == {p_pos_q, p_seg_q};
    // Fires on the single cycle the run counter would step onto P_STABLE.
    accept    = (pos_class == PosValid) && same && (run_q == RunW'(P_STABLE - 1));
    publish   = (state_q == StCollect) && (mask_q == 4'hF);

    if (pos_class != PosValid) begin
      run_d = '0;
    end else if (!same) begin
      run_d = RunW'(1);
    end else if (run_q != RunMax) begin
      run_d = run_q + RunW'(1);
    end else begin
      run_d = run_q;
    end

    mask_d = publish ? 4'h0 : mask_q;
    if (accept) begin
      mask_d = mask_d | s_pos_q;
    end

    err_d = ((pos_class == PosIllegal) && !same) || (accept && !glyph_legal);

    if (publish) begin
      tmo_cnt_d = '0;
      tmo_d     = 1'b0;
    end else begin
      tmo_cnt_d = (tmo_cnt_q == TmoMax) ? tmo_cnt_q : tmo_cnt_q + TmoW'(1);
      tmo_d     = tmo_q || (tmo_cnt_d == TmoMax);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_pos_q   <= '0;
      s_seg_q   <= '0;
      p_pos_q   <= '0;
      p_seg_q   <= '0;
      run_q     <= '0;
      tmo_cnt_q <= '0;
      mask_q    <= '0;
      shadow_q  <= {4{ASCII_BLANK}};
      dp_sh_q   <= '0;
      data_q    <= {4{ASCII_BLANK}};
      dp_q      <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
      state_q   <= StCollect;
    end else begin
      s_pos_q   <= i_seg_pos;
      s_seg_q   <= i_seg;
      p_pos_q   <= s_pos_q;
      p_seg_q   <= s_seg_q;
      run_q     <= run_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
      mask_q    <= mask_d;
      err_q     <= err_d;
      valid_q   <= publish;
      changed_q <= publish && (shadow_q != data_q);
      if (publish) begin
        data_q <= shadow_q;
        dp_q   <= dp_sh_q;
      end
      for (int i = 0; i < 4; i++) begin
        if (accept && s_pos_q[i]) begin
          shadow_q[i] <= glyph_ascii;
          dp_sh_q[i]  <= s_seg_q[SEG_DP];
        end
      end
      unique case (state_q)
        StCollect: if (mask_q == 4'hF) state_q <= StPublish;
        StPublish: state_q <= StCollect;
      endcase
    end
  end

  assign o_data    = data_q;
  assign o_dp      = dp_q;
  assign o_valid   = valid_q;
  assign o_changed = changed_q;
  assign o_err     = err_q;
  assign o_timeout = tmo_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed scans plus random bus traffic against a history model.
module tb_seg_scan_capture;

  localparam int unsigned PStable  = 16;
  localparam int unsigned PTimeout = 400;
  localparam int Hold = 40;
  localparam int Gap  = 2;

  logic        clk, rst;
  logic [3:0]  i_seg_pos;
  logic [7:0]  i_seg;
  logic [31:0] o_data;
  logic [3:0]  o_dp;
  logic        o_valid, o_changed, o_err, o_timeout;

  seg_scan_capture #(.P_STABLE(PStable), .P_TIMEOUT(PTimeout)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_seg_pos(i_seg_pos),
    .i_seg    (i_seg),
    .o_data   (o_data),
    .o_dp     (o_dp),
    .o_valid  (o_valid),
    .o_changed(o_changed),
    .o_err    (o_err),
    .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int nv = 0, nc = 0, ne = 0;

  logic [6:0] glyph_tab [18] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
                                 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h40, 7'h00};
  string char_tab = "0123456789ABCDEF- ";

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: a digit is taken when the last PStable bus samples agree, carry a
  // one-hot position, and the sample before them differs.
  logic [31:0] m_data, m_shadow;
  logic [3:0]  m_dp, m_dpsh, m_mask;
  logic        m_valid, m_changed, m_err, m_tmo;
  int          tcnt;
  bit          m_init = 1'b0;
  logic [11:0] hist[$];

  function automatic void decode(input logic [6:0] pat, output logic [7:0] ch, output bit ok);
    ch = 8'h3F;
    ok = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (glyph_tab[i] == pat) begin
        ch = char_tab[i];
        ok = 1'b1;
      end
    end
  endfunction

  task automatic model_reset();
    m_data = 32'h20202020; m_shadow = 32'h20202020;
    m_dp = '0; m_dpsh = '0; m_mask = '0;
    m_valid = 1'b0; m_changed = 1'b0; m_err = 1'b0; m_tmo = 1'b0;
    tcnt = 0;
    hist.delete();
    for (int k = 0; k <= int'(PStable); k++) hist.push_back(12'h000);
    m_init = 1'b1;
  endtask

  task automatic model_step();
    logic [11:0] h, cur;
    logic [7:0]  ch;
    bit          same, acc, ok, err;
    int          idx;
    cur  = {i_seg_pos, i_seg};
    h    = hist[PStable];
    same = 1'b1;
    for (int k = 1; k <= int'(PStable); k++) if (hist[k] != h) same = 1'b0;
    acc = same && (hist[0] != h) && ($countones(h[11:8]) == 1);
    err = ($countones(h[11:8]) > 1) && (h != hist[PStable-1]);
    m_valid   = (m_mask == 4'hF);
    m_changed = m_valid && (m_shadow != m_data);
    if (m_valid) begin
      m_data = m_shadow;
      m_dp   = m_dpsh;
      m_mask = '0;
    end
    if (acc) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (h[8+i]) idx = i;
      decode(h[6:0], ch, ok);
      m_shadow[idx*8 +: 8] = ch;
      m_dpsh[idx] = h[7];
      m_mask[idx] = 1'b1;
      if (!ok) err = 1'b1;
    end
    m_err = err;
    if (m_valid) begin
      tcnt  = 0;
      m_tmo = 1'b0;
    end else begin
      if (tcnt < int'(PTimeout)) tcnt++;
      if (tcnt >= int'(PTimeout)) m_tmo = 1'b1;
    end
    void'(hist.pop_front());
    hist.push_back(cur);
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else if (m_init) model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_init) begin
      chk("cycle", {24'd0, o_data, o_dp, o_valid, o_changed, o_err, o_timeout},
          {24'd0, m_data, m_dp, m_valid, m_changed, m_err, m_tmo});
      if (o_valid) nv++;
      if (o_changed) nc++;
      if (o_err) ne++;
    end
  end

  task automatic drive(input logic [3:0] p, input logic [7:0] s, input int n);
    i_seg_pos = p;
    i_seg     = s;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic digit(input int i, input int g, input bit dp);
    drive(4'(1 << i), {dp, glyph_tab[g]}, Hold);
    drive(4'b0000, 8'h00, Gap);
  endtask

  task automatic scan(input int g3, input int g2, input int g1, input int g0,
                      input logic [3:0] dp);
    digit(3, g3, dp[3]);
    digit(2, g2, dp[2]);
    digit(1, g1, dp[1]);
    digit(0, g0, dp[0]);
  endtask

  initial begin
    int lat, v0, e0, kind;
    logic [3:0] rp;
    logic [7:0] rs;
    rst = 1'b1;
    i_seg_pos = '0;
    i_seg = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_data", o_data, 32'h20202020);
    chk("rst_flags", {o_dp, o_valid, o_changed, o_err, o_timeout}, 0);
    rst = 1'b0;

    // First scan "1234"; measure pin-to-valid latency on the closing digit.
    digit(3, 1, 1'b0);
    digit(2, 2, 1'b0);
    digit(1, 3, 1'b0);
    i_seg_pos = 4'b0001;
    i_seg = {1'b0, glyph_tab[4]};
    lat = 0;
    for (int c = 0; c < Hold; c++) begin
      @(negedge clk);
      if (o_valid && lat == 0) lat = c + 1;
    end
    #1;
    drive(4'b0000, 8'h00, Gap);
    chk("latency", lat, PStable + 2);
    chk("scan1_data", o_data, 32'h31323334);
    chk("scan1_dp", o_dp, 4'b0000);
    chk("scan1_pulses", {nv, nc}, {32'd1, 32'd1});

    scan(1, 2, 3, 4, 4'b0000);
    scan(1, 2, 3, 4, 4'b0000);
    chk("repeat_pulses", {nv, nc}, {32'd3, 32'd1});

    scan(1, 2, 3, 4, 4'b0100);
    chk("dp_data", o_data, 32'h31323334);
    chk("dp_bits", o_dp, 4'b0100);

    e0 = ne;
    v0 = nv;
    drive(4'b0010, {1'b0, glyph_tab[8]}, 5);
    drive(4'b0000, 8'h00, Gap);
    chk("glitch_data", o_data, 32'h31323334);
    chk("glitch_err", ne - e0, 0);
    chk("glitch_nopub", nv - v0, 0);

    digit(3, 5, 1'b0);
    digit(2, 6, 1'b0);
    e0 = ne;
    v0 = nv;
    drive(4'b0110, {1'b0, glyph_tab[1]}, 20);
    drive(4'b0000, 8'h00, Gap);
    chk("illegal_err", ne - e0, 1);
    chk("illegal_nopub", nv - v0, 0);
    digit(1, 7, 1'b0);
    digit(0, 8, 1'b0);
    chk("illegal_frame", o_data, 32'h35363738);
    chk("illegal_pub", nv - v0, 1);

    e0 = ne;
    v0 = nv;
    digit(3, 1, 1'b0);
    digit(2, 2, 1'b0);
    digit(1, 3, 1'b0);
    drive(4'b0001, 8'h49, Hold);
    drive(4'b0000, 8'h00, Gap);
    chk("badglyph_data", o_data, 32'h3132333F);
    chk("badglyph_err", ne - e0, 1);
    chk("badglyph_pub", nv - v0, 1);

    drive(4'b0000, 8'h00, PTimeout + 5);
    chk("timeout", o_timeout, 1'b1);

    digit(3, 9, 1'b0);
    digit(2, 9, 1'b0);
    rst = 1'b1;
    #2;
    chk("midrst_data", o_data, 32'h20202020);
    chk("midrst_flags", {o_dp, o_valid, o_changed, o_err, o_timeout}, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    v0 = nv;
    digit(1, 3, 1'b0);
    digit(0, 4, 1'b0);
    chk("midrst_discard", nv - v0, 0);
    scan(1, 2, 3, 4, 4'b0000);
    chk("midrst_frame", o_data, 32'h31323334);
    chk("midrst_tmo", o_timeout, 1'b0);
    chk("midrst_pub", nv - v0, 1);

    // Random bus traffic around the stability threshold, checked cycle by cycle.
    for (int e = 0; e < 160; e++) begin
      kind = int'($urandom_range(0, 9));
      rp = 4'(1 << $urandom_range(0, 3));
      rs = {1'($urandom_range(0, 1)), glyph_tab[$urandom_range(0, 17)]};
      if ($urandom_range(0, 7) == 0) rs[6:0] = 7'($urandom);
      case (kind)
        0, 1, 2, 3, 4, 5: drive(rp, rs, int'($urandom_range(PStable - 2, PStable + 6)));
        6: drive(rp, rs, int'($urandom_range(1, 5)));
        7: drive(4'b0000, 8'h00, int'($urandom_range(1, 4)));
        8: begin
          rp = 4'($urandom_range(0, 15));
          if ($countones(rp) < 2) rp = 4'b1010;
          drive(rp, rs, int'($urandom_range(1, 20)));
        end
        default: drive(rp, rs, int'($urandom_range(30, 60)));
      endcase
    end
    drive(4'b0000, 8'h00, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
